// File: rtl/dma_read_engine.sv
`default_nettype none
// dma_read_engine: AXI4 read master that fetches a strided 2-D region (rows x row_beats) into a stream.
// Revision 1.0 - initial release.
module dma_read_engine #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 256,
  parameter int MAX_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [4:0]        row_beats,
  input  logic [15:0]       rows,
  input  logic [ADDR_W-1:0] row_stride,
  output logic              busy,
  output logic              dma_done,
  output logic              dma_err,
  output logic [DATA_W-1:0] dma_data,
  output logic              dma_valid,
  input  logic              dma_ready,
  output logic              dma_rlast,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [5:0] MAX_LEN_C = 6'(MAX_LEN);

  state_t            state_q;
  logic [ADDR_W-1:0] row_addr_q;
  logic [ADDR_W-1:0] stride_q;
  logic [4:0]        row_beats_q;
  logic [4:0]        beat_cnt_q;
  logic [15:0]       rows_q;
  logic [15:0]       row_cnt_q;
  logic [7:0]        arlen_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              arvalid_q;

  logic w_in_data;
  logic w_beat;
  logic w_row_end;
  logic w_last_row;
  logic w_cmd_bad;

  assign w_in_data  = (state_q == S_DATA);
  assign w_beat     = w_in_data & m_rvalid & dma_ready;
  // Row end is decided by our own counter; the slave's m_rlast is only cross-checked.
  assign w_row_end  = (beat_cnt_q == row_beats_q - 5'd1);
  assign w_last_row = ((row_cnt_q + 16'd1) == rows_q);
  assign w_cmd_bad  = (row_beats == 5'd0) || (rows == 16'd0) || ({1'b0, row_beats} > MAX_LEN_C);

  // R channel is a combinational pass-through while a burst is outstanding.
  assign dma_data  = m_rdata;
  assign dma_valid = w_in_data & m_rvalid;
  assign dma_rlast = w_in_data & m_rlast;
  assign m_rready  = w_in_data & dma_ready;

  assign busy      = busy_q;
  assign dma_done  = done_q;
  assign dma_err   = err_q;
  assign m_arvalid = arvalid_q;
  assign m_araddr  = row_addr_q;
  assign m_arlen   = arlen_q;
  assign m_arsize  = 3'd5;
  assign m_arburst = 2'b01;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_addr_q  <= '0;
      stride_q    <= '0;
      row_beats_q <= '0;
      beat_cnt_q  <= '0;
      rows_q      <= '0;
      row_cnt_q   <= '0;
      arlen_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      arvalid_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            row_addr_q  <= addr;
            stride_q    <= row_stride;
            row_beats_q <= row_beats;
            rows_q      <= rows;
            beat_cnt_q  <= '0;
            row_cnt_q   <= '0;
            arlen_q     <= {3'b000, row_beats - 5'd1};
            busy_q      <= 1'b1;
            if (w_cmd_bad) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              err_q     <= 1'b0;
              arvalid_q <= 1'b1;
              state_q   <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (m_arready) begin
            arvalid_q <= 1'b0;
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            if ((m_rresp != 2'b00) || (m_rlast && !w_row_end)) begin
              err_q <= 1'b1;
            end
            if (w_row_end) begin
              beat_cnt_q <= '0;
              row_addr_q <= row_addr_q + stride_q;
              row_cnt_q  <= row_cnt_q + 16'd1;
              if (w_last_row) begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                arvalid_q <= 1'b1;
                state_q   <= S_ADDR;
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + 5'd1;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_read_engine.sv
`default_nettype none
// tb_dma_read_engine: directed bench; a queue model of the expected AR/beat stream is checked every cycle.
// Revision 1.0 - initial release.
module tb_dma_read_engine;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 256;
  localparam int MAX_LEN = 16;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
  } ar_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    bit                last;
    bit                err;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start;
  logic [ADDR_W-1:0] addr;
  logic [4:0]        row_beats;
  logic [15:0]       rows;
  logic [ADDR_W-1:0] row_stride;
  logic              busy, dma_done, dma_err, dma_valid, dma_ready, dma_rlast;
  logic [DATA_W-1:0] dma_data;
  logic [ADDR_W-1:0] m_araddr;
  logic [7:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic [1:0]        m_arburst;
  logic              m_arvalid, m_arready;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast, m_rvalid, m_rready;

  int errors = 0;
  int checks = 0;

  ar_t               exp_ar[$];
  beat_t             exp_beat[$];
  logic [ADDR_W-1:0] ar_log[$];
  logic [7:0]        arlen_log[$];
  beat_t             cmp_b;
  int  beats_seen   = 0;
  bit  cmd_active   = 1'b0;
  bit  cmd_illegal  = 1'b0;
  bit  model_err    = 1'b0;
  bit  done_due     = 1'b0;
  bit  outstanding  = 1'b0;
  bit  ready_toggle = 1'b0;
  int  ar_delay     = 0;
  int  sl_err_beat  = -1;
  int  sl_rlast_bad = -1;
  int  cmd_id       = 0;

  always #5 clk = ~clk;

  dma_read_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .row_beats(row_beats), .rows(rows),
    .row_stride(row_stride), .busy(busy), .dma_done(dma_done), .dma_err(dma_err),
    .dma_data(dma_data), .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_rlast(dma_rlast),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  function automatic logic [DATA_W-1:0] beat_data(input logic [ADDR_W-1:0] a, input int b);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) begin
      d[i*32 +: 32] = a ^ (32'(b) << 8) ^ (32'(i) * 32'h0101_0101);
    end
    return d;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave: accepts AR after ar_delay wait cycles, then streams len+1 beats with m_rvalid held high.
  initial begin : slave
    logic [ADDR_W-1:0] sl_addr;
    logic [7:0]        sl_len;
    int  b, gbeat, last_id;
    bit  hs, ab;
    gbeat = 0; last_id = -1;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00; m_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst || !m_arvalid) begin
        @(posedge clk); #1;
        m_arready = (ar_delay == 0);
        continue;
      end
      sl_addr = m_araddr;
      sl_len  = m_arlen;
      if (cmd_id != last_id) begin
        gbeat = 0;
        last_id = cmd_id;
      end
      if (!m_arready) begin
        repeat (ar_delay) @(posedge clk);
        #1 m_arready = 1'b1;
      end
      @(posedge clk); #1;
      m_arready   = (ar_delay == 0);
      outstanding = 1'b1;
      b = 0;
      ab = 1'b0;
      while ((b <= int'(sl_len)) && !ab) begin
        m_rvalid = 1'b1;
        m_rdata  = beat_data(sl_addr, b);
        m_rresp  = (gbeat == sl_err_beat) ? 2'b10 : 2'b00;
        m_rlast  = (b == int'(sl_len)) || (gbeat == sl_rlast_bad);
        @(negedge clk);
        hs = m_rready;
        ab = rst;
        @(posedge clk); #1;
        if (!ab && hs) begin
          b++;
          gbeat++;
        end
      end
      m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
      outstanding = 1'b0;
    end
  end

  initial begin : ready_drv
    dma_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      dma_ready = ready_toggle ? ~dma_ready : 1'b1;
    end
  end

  // Every-cycle compare against the model queues.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (cmd_active) begin
        chk(busy === 1'b1, "busy_during_cmd", 64'(busy), 64'(1));
        chk(dma_err === model_err, "dma_err_track", 64'(dma_err), 64'(model_err));
      end
      chk(m_rready === (outstanding & dma_ready), "m_rready", 64'(m_rready), 64'(outstanding & dma_ready));
      chk(dma_valid === (outstanding & m_rvalid), "dma_valid", 64'(dma_valid), 64'(outstanding & m_rvalid));
      chk(!(m_arvalid && outstanding), "ar_while_burst", 64'(m_arvalid), 64'(0));
      if (!outstanding) chk(dma_rlast === 1'b0, "rlast_idle", 64'(dma_rlast), 64'(0));
      if (m_arvalid) begin
        if (exp_ar.size() == 0) begin
          chk(1'b0, "ar_unexpected", 64'(m_araddr), 64'(0));
        end else begin
          chk(m_araddr === exp_ar[0].addr, "araddr", 64'(m_araddr), 64'(exp_ar[0].addr));
          chk(m_arlen === exp_ar[0].len, "arlen", 64'(m_arlen), 64'(exp_ar[0].len));
          chk((m_arsize === 3'd5) && (m_arburst === 2'b01), "arsize_burst", 64'({m_arsize, m_arburst}), 64'({3'd5, 2'b01}));
          if (m_arready) begin
            ar_log.push_back(m_araddr);
            arlen_log.push_back(m_arlen);
            void'(exp_ar.pop_front());
          end
        end
      end
      if (done_due) begin
        chk(dma_done === 1'b1, "done_after_last_beat", 64'(dma_done), 64'(1));
        done_due = 1'b0;
      end else if (dma_done) begin
        chk(cmd_illegal, "done_unexpected", 64'(dma_done), 64'(0));
      end
      if (dma_valid && dma_ready) begin
        if (exp_beat.size() == 0) begin
          chk(1'b0, "beat_extra", 64'(dma_data[63:0]), 64'(0));
        end else begin
          cmp_b = exp_beat.pop_front();
          checks++;
          if (dma_data !== cmp_b.data) begin
            errors++;
            $display("FAIL beat_data: got %h expected %h", dma_data, cmp_b.data);
          end
          chk(dma_rlast === cmp_b.last, "beat_rlast", 64'(dma_rlast), 64'(cmp_b.last));
          if (cmp_b.err) model_err = 1'b1;
          beats_seen++;
          if (exp_beat.size() == 0) done_due = 1'b1;
        end
      end
    end
  end

  task automatic issue_cmd(input logic [ADDR_W-1:0] a, input int rb, input int nrows,
                           input logic [ADDR_W-1:0] stride, input int ard, input bit tog,
                           input int eb, input int lb);
    ar_t   x;
    beat_t t;
    int    g;
    exp_ar.delete(); exp_beat.delete(); ar_log.delete(); arlen_log.delete();
    beats_seen = 0;
    ar_delay = ard; ready_toggle = tog; sl_err_beat = eb; sl_rlast_bad = lb;
    cmd_illegal = (rb == 0) || (nrows == 0);
    if (!cmd_illegal) begin
      for (int r = 0; r < nrows; r++) begin
        x.addr = a + 32'(r) * stride;
        x.len  = 8'(rb - 1);
        exp_ar.push_back(x);
        for (int b = 0; b < rb; b++) begin
          g = r * rb + b;
          t.data = beat_data(x.addr, b);
          t.last = (b == rb - 1) || (g == lb);
          t.err  = (g == eb) || ((g == lb) && (b != rb - 1));
          exp_beat.push_back(t);
        end
      end
    end
    @(posedge clk); #1;
    cmd_id++;
    addr = a; row_beats = 5'(rb); rows = 16'(nrows); row_stride = stride;
    start = 1'b1;
    model_err = cmd_illegal;
    done_due = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cmd_active = 1'b1;
  endtask

  task automatic wait_done(input bit exp_err, input int max_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dma_done && n < max_cyc);
    chk(dma_done === 1'b1, "done_within_budget", 64'(dma_done), 64'(1));
    chk(dma_err === exp_err, "err_at_done", 64'(dma_err), 64'(exp_err));
    cmd_active = 1'b0;
    @(negedge clk);
    chk(busy === 1'b0, "busy_after_done", 64'(busy), 64'(0));
    chk(dma_done === 1'b0, "done_one_cycle", 64'(dma_done), 64'(0));
    chk(dma_err === exp_err, "err_sticky", 64'(dma_err), 64'(exp_err));
    chk((exp_ar.size() == 0) && (exp_beat.size() == 0), "model_drained",
        64'(exp_ar.size() + exp_beat.size()), 64'(0));
  endtask

  task automatic check_reset_vals();
    chk(busy === 1'b0, "rst_busy", 64'(busy), 64'(0));
    chk(dma_done === 1'b0, "rst_done", 64'(dma_done), 64'(0));
    chk(dma_err === 1'b0, "rst_err", 64'(dma_err), 64'(0));
    chk(dma_valid === 1'b0, "rst_valid", 64'(dma_valid), 64'(0));
    chk(dma_rlast === 1'b0, "rst_rlast", 64'(dma_rlast), 64'(0));
    chk(m_arvalid === 1'b0, "rst_arvalid", 64'(m_arvalid), 64'(0));
    chk(m_rready === 1'b0, "rst_rready", 64'(m_rready), 64'(0));
    chk(m_araddr === '0, "rst_araddr", 64'(m_araddr), 64'(0));
    chk(m_arlen === 8'd0, "rst_arlen", 64'(m_arlen), 64'(0));
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    start = 1'b0; addr = '0; row_beats = '0; rows = '0; row_stride = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1 rst = 1'b0;

    // Single row, zero-wait slave.
    issue_cmd(32'h0000_1000, 2, 1, 32'h0, 0, 1'b0, -1, -1);
    wait_done(1'b0, 200);
    chk(ar_log.size() == 1, "t1_ar_count", 64'(ar_log.size()), 64'(1));
    if (ar_log.size() > 0) chk(ar_log[0] === 32'h0000_1000, "t1_araddr", 64'(ar_log[0]), 64'h1000);
    if (arlen_log.size() > 0) chk(arlen_log[0] === 8'd1, "t1_arlen", 64'(arlen_log[0]), 64'd1);
    chk(beats_seen == 2, "t1_beats", 64'(beats_seen), 64'(2));

    // Three rows with stride; a start pulse mid-command must be ignored.
    issue_cmd(32'h0000_2000, 4, 3, 32'h400, 0, 1'b0, -1, -1);
    repeat (3) @(posedge clk);
    #1 addr = 32'hDEAD_0000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(1'b0, 400);
    chk(ar_log.size() == 3, "t2_ar_count", 64'(ar_log.size()), 64'(3));
    if (ar_log.size() == 3) begin
      chk(ar_log[0] === 32'h2000, "t2_ar0", 64'(ar_log[0]), 64'h2000);
      chk(ar_log[1] === 32'h2400, "t2_ar1", 64'(ar_log[1]), 64'h2400);
      chk(ar_log[2] === 32'h2800, "t2_ar2", 64'(ar_log[2]), 64'h2800);
      chk(arlen_log[2] === 8'd3, "t2_arlen", 64'(arlen_log[2]), 64'd3);
    end
    chk(beats_seen == 12, "t2_beats", 64'(beats_seen), 64'(12));

    // Back-pressured stream and slow AR acceptance.
    issue_cmd(32'h0000_3000, 8, 2, 32'h100, 3, 1'b1, -1, -1);
    wait_done(1'b0, 800);
    chk(beats_seen == 16, "t3_beats", 64'(beats_seen), 64'(16));

    // SLVERR on beat 2 of 4: data still forwarded, error sticky.
    issue_cmd(32'h0000_4000, 4, 1, 32'h0, 0, 1'b0, 1, -1);
    wait_done(1'b1, 200);
    chk(beats_seen == 4, "t4_beats", 64'(beats_seen), 64'(4));

    // Early m_rlast on beat 2 of row 0: flags error, row end follows counter.
    issue_cmd(32'h0000_5000, 4, 2, 32'h80, 0, 1'b0, -1, 1);
    @(negedge clk);
    chk(dma_err === 1'b0, "t5_err_cleared_by_start", 64'(dma_err), 64'(0));
    wait_done(1'b1, 300);
    chk(beats_seen == 8, "t5_beats", 64'(beats_seen), 64'(8));

    // Row address wraps modulo 2^32.
    issue_cmd(32'hFFFF_FF00, 1, 3, 32'h100, 0, 1'b0, -1, -1);
    wait_done(1'b0, 300);
    if (ar_log.size() == 3) begin
      chk(ar_log[1] === 32'h0000_0000, "t6_wrap1", 64'(ar_log[1]), 64'h0);
      chk(ar_log[2] === 32'h0000_0100, "t6_wrap2", 64'(ar_log[2]), 64'h100);
    end else begin
      chk(1'b0, "t6_ar_count", 64'(ar_log.size()), 64'(3));
    end

    // Illegal commands: no AR, error, prompt done.
    issue_cmd(32'h0000_6000, 4, 0, 32'h0, 0, 1'b0, -1, -1);
    wait_done(1'b1, 2);
    issue_cmd(32'h0000_6000, 0, 2, 32'h0, 0, 1'b0, -1, -1);
    wait_done(1'b1, 2);

    // Reset with two beats of the row still outstanding.
    issue_cmd(32'h0000_7000, 4, 1, 32'h0, 0, 1'b0, -1, -1);
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (beats_seen < 2 && n < 100);
    chk(beats_seen == 2, "t8_reached_two_beats", 64'(beats_seen), 64'(2));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_ar.delete(); exp_beat.delete();
    cmd_active = 1'b0; done_due = 1'b0;
    @(negedge clk);
    check_reset_vals();

    // Full-length row after reset.
    issue_cmd(32'h0000_8000, MAX_LEN, 2, 32'h800, 0, 1'b0, -1, -1);
    wait_done(1'b0, 400);
    chk(beats_seen == 2 * MAX_LEN, "t9_beats", 64'(beats_seen), 64'(2 * MAX_LEN));
    if (arlen_log.size() > 0) chk(arlen_log[0] === 8'd15, "t9_arlen", 64'(arlen_log[0]), 64'd15);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dma_read_engine.md
DMA_READ_ENGINE -- requirements
Module: dma_read_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI/command address width.
REQ-002 SHALL have parameter DATA_W, default 256, AXI read data and output stream width.
REQ-003 SHALL have parameter MAX_LEN, default 16, maximum beats per row burst.
REQ-004 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle command pulse, accepted only in IDLE.
REQ-007 addr  in  ADDR_W  byte address of first row, 32-byte aligned.
REQ-008 row_beats  in  5  beats per row, legal 1..MAX_LEN.
REQ-009 rows  in  16  number of rows, legal 1..65535.
REQ-010 row_stride  in  ADDR_W  byte distance between consecutive row start addresses.
REQ-011 busy  out  1  high from command accept until done pulse, inclusive.
REQ-012 dma_done  out  1  one-cycle pulse after last beat of last row is delivered.
REQ-013 dma_err  out  1  sticky error flag, cleared on next accepted start.
REQ-014 dma_data  out  DATA_W  stream data; dma_valid out 1; dma_ready in 1; dma_rlast out 1 (last beat of each row).
REQ-015 m_araddr out ADDR_W; m_arlen out 8; m_arsize out 3; m_arburst out 2; m_arvalid out 1; m_arready in 1.
REQ-016 m_rdata in DATA_W; m_rresp in 2; m_rlast in 1; m_rvalid in 1; m_rready out 1.

Function
REQ-017 SHALL implement FSM IDLE -> ADDR -> DATA -> (ADDR | DONE) -> IDLE.
REQ-018 IDLE: start=1 latches addr, row_beats, rows, row_stride; clears dma_err; next state ADDR; start outside IDLE ignored.
REQ-019 ADDR: m_arvalid=1, m_araddr=current row address, m_arlen=row_beats-1, m_arsize=5, m_arburst=2'b01; held stable until m_arvalid&m_arready, then DATA.
REQ-020 One burst outstanding at most; no new AR before the previous burst's final R beat.
REQ-021 DATA: R channel passed through combinationally: dma_data=m_rdata, dma_valid=m_rvalid, m_rready=dma_ready, dma_rlast=m_rlast; beat transfers when m_rvalid&dma_ready.
REQ-022 Internal beat counter increments per transferred beat; row end = counter reaches row_beats-1 on a transfer, regardless of m_rlast.
REQ-023 m_rlast arriving on a beat other than counter row_beats-1 SHALL set dma_err; row end still follows the counter.
REQ-024 Any transferred beat with m_rresp!=2'b00 SHALL set dma_err; data still forwarded.
REQ-025 At row end: row address += row_stride (modulo 2^ADDR_W), row counter +1; if rows completed then DONE, else ADDR.
REQ-026 DONE: dma_done=1 for exactly one cycle, busy=1 that cycle, next state IDLE; earliest new start accepted cycle after DONE.
REQ-027 Outside DATA: dma_valid=0, m_rready=0, dma_rlast=0; outside ADDR: m_arvalid=0.
REQ-028 row_beats=0 or rows=0 at start SHALL be treated as illegal: no AR issued, dma_err=1, straight to DONE.
REQ-029 4KB-boundary crossing is not checked; caller guarantees each row stays within one 4KB page.
REQ-030 Minimum latency start -> first m_arvalid: 1 cycle; throughput one beat per cycle when m_rvalid and dma_ready both held high.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE and clear all counters and latched command.
REQ-032 Reset values: busy=0, dma_done=0, dma_err=0, dma_valid=0, dma_rlast=0, m_arvalid=0, m_rready=0, m_araddr=0, m_arlen=0.
REQ-033 Reset mid-burst SHALL abandon the transfer without draining the R channel; system reset is assumed to cover the slave.

Verification
REQ-034 addr=0x1000, row_beats=2, rows=1, slave zero-wait -> AR addr 0x1000 len 1; 2 beats, dma_rlast on beat 2; dma_done 1 cycle after; dma_err=0.
REQ-035 addr=0x2000, row_beats=4, rows=3, row_stride=0x400 -> AR addresses 0x2000, 0x2400, 0x2800 each len 3; 12 beats in order; single dma_done.
REQ-036 dma_ready toggled 1/0 each cycle, m_arready delayed 3 cycles -> m_araddr/m_arlen stable while waiting; no beat lost or duplicated; m_rready mirrors dma_ready.
REQ-037 beat 2 of 4 returns m_rresp=2'b10 -> all 4 beats forwarded, dma_err=1 after beat, remains 1 through done until next start clears it.
REQ-038 rows=0 at start -> no m_arvalid ever, dma_err=1, dma_done pulses within 2 cycles.
REQ-039 rst asserted during DATA with 2 beats remaining -> next cycle all outputs at reset values; subsequent start completes normally.
